// File: rtl/debounce_ctrl.sv
// debounce_ctrl
//   Multi-channel contact debouncer with a round-robin edge-event output.
//   A prescaler produces one sample tick every PRESCALE clocks. On each tick
//   every channel compares its sample with its debounced level; STABLE_CNT
//   consecutive differing samples toggle the level and latch a pending edge
//   event. Pending events are offered one at a time over a valid/ready
//   handshake, arbitrated round-robin.
//
//   Optional build macro: DEBOUNCE_SYNC2_EN -- inserts a 2-flop synchronizer
//   (reset to 0) on data ahead of sampling. Undefined: data is sampled raw.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   data         raw contact inputs, one bit per channel
//   level        debounced level per channel
//   sample_tick  one-cycle pulse on each sampling instant
//   evt_valid    an edge event is offered
//   evt_ready    consumer accepts the offered event
//   evt_ch       channel index of the offered event
//   evt_rise     1 = rising (press), 0 = falling (release)
//   evt_ovf      sticky: an undelivered event was overwritten
module debounce_ctrl #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned STABLE_CNT = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CH_NUM-1:0]         data,
  output logic [CH_NUM-1:0]         level,
  output logic                      sample_tick,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(CH_NUM)-1:0] evt_ch,
  output logic                      evt_rise,
  output logic                      evt_ovf
);

  localparam int unsigned CH_W  = $clog2(CH_NUM);
  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } state_t;

  // Round-robin search: first set bit of req starting at index start,
  // wrapping modulo CH_NUM. Result is {found, index}.
  function automatic logic [CH_W:0] rr_pick(input logic [CH_NUM-1:0] req,
                                            input int unsigned       start);
    logic [CH_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      idx = (start + i) % CH_NUM;
      if (!res[CH_W] && req[idx]) begin
        res = {1'b1, CH_W'(idx)};
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Sample source
  // ---------------------------------------------------------------------
  logic [CH_NUM-1:0] samp;

`ifdef DEBOUNCE_SYNC2_EN
  logic [CH_NUM-1:0] sync1_q, sync1_d;
  logic [CH_NUM-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = data;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = data;
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PS_W-1:0]   prsc_q, prsc_d;
  logic              tick_q, tick_d;
  logic [CNT_W-1:0]  cnt_q [CH_NUM];
  logic [CNT_W-1:0]  cnt_d [CH_NUM];
  logic [CH_NUM-1:0] level_q, level_d;
  logic [CH_NUM-1:0] pend_q, pend_d;
  logic [CH_NUM-1:0] edge_q, edge_d;
  logic [CH_NUM-1:0] evt_set;
  state_t            state_q, state_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic              evt_rise_q, evt_rise_d;
  logic              ovf_q, ovf_d;
  logic [CH_W-1:0]   rr_q, rr_d;

  logic              hs;
  logic [CH_NUM-1:0] clr;
  logic [CH_W:0]     pick_idle;
  logic [CH_W:0]     pick_next;

  // ---------------------------------------------------------------------
  // Prescaler: tick_q is high exactly while prsc_q == PRESCALE-1.
  // ---------------------------------------------------------------------
  always_comb begin
    if (prsc_q == PS_W'(PRESCALE - 1)) begin
      prsc_d = '0;
    end else begin
      prsc_d = prsc_q + 1'b1;
    end
    tick_d = (prsc_d == PS_W'(PRESCALE - 1));
  end

  // ---------------------------------------------------------------------
  // Per-channel stability counters. A counter sits at most at
  // STABLE_CNT-1; the sample that would reach STABLE_CNT toggles the
  // level and clears it instead, so it never wraps.
  // ---------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    evt_set = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      cnt_d[c] = cnt_q[c];
      if (tick_q) begin
        if (samp[c] != level_q[c]) begin
          if (cnt_q[c] == CNT_W'(STABLE_CNT - 1)) begin
            level_d[c] = ~level_q[c];
            cnt_d[c]   = '0;
            evt_set[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end else begin
          cnt_d[c] = '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pending flags, overflow and output FSM.
  // The offered evt_rise is captured at grant time, so a later overwrite
  // of the channel's edge does not disturb the offer in flight.
  // ---------------------------------------------------------------------
  always_comb begin
    hs  = evt_valid_q && evt_ready;
    clr = hs ? (CH_NUM'(1) << evt_ch_q) : '0;

    pend_d = (pend_q & ~clr) | evt_set;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      edge_d[c] = evt_set[c] ? level_d[c] : edge_q[c];
    end
    // A new event on a flag that is still pending and not being consumed
    // this cycle loses the earlier edge.
    ovf_d = ovf_q | (|(evt_set & pend_q & ~clr));

    pick_idle = rr_pick(pend_q, (32'(rr_q) + 32'd1) % CH_NUM);
    pick_next = rr_pick(pend_q & ~clr, (32'(evt_ch_q) + 32'd1) % CH_NUM);

    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;
    rr_d        = rr_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_idle[CH_W]) begin
          state_d     = ST_OFFER;
          evt_valid_d = 1'b1;
          evt_ch_d    = pick_idle[CH_W-1:0];
          evt_rise_d  = edge_q[pick_idle[CH_W-1:0]];
        end
      end
      ST_OFFER: begin
        if (hs) begin
          rr_d = evt_ch_q;
          if (pick_next[CH_W]) begin
            evt_ch_d   = pick_next[CH_W-1:0];
            evt_rise_d = edge_q[pick_next[CH_W-1:0]];
          end else begin
            state_d     = ST_IDLE;
            evt_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prsc_q      <= '0;
      tick_q      <= 1'b0;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        cnt_q[c] <= '0;
      end
      level_q     <= '0;
      pend_q      <= '0;
      edge_q      <= '0;
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
      ovf_q       <= 1'b0;
      rr_q        <= CH_W'(CH_NUM - 1);
    end else begin
      prsc_q      <= prsc_d;
      tick_q      <= tick_d;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
      level_q     <= level_d;
      pend_q      <= pend_d;
      edge_q      <= edge_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
      ovf_q       <= ovf_d;
      rr_q        <= rr_d;
    end
  end

  assign level       = level_q;
  assign sample_tick = tick_q;
  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_ch_q;
  assign evt_rise    = evt_rise_q;
  assign evt_ovf     = ovf_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// tb_debounce_ctrl
//   Randomized bench for debounce_ctrl with an in-bench reference model.
//   The model tracks, per channel, the run of samples disagreeing with the
//   debounced level, the pending edge per channel and the single offered
//   event; a compare process checks every output on every falling edge.
//   Directed scenarios pin the model with hand-computed literal values.
module tb_debounce_ctrl;

  localparam int P = 4;
  localparam int S = 3;
  localparam int N = 4;
`ifdef DEBOUNCE_SYNC2_EN
  localparam int L = 16;  // edge (after reset) where a level lands when data changes just before the first tick
`else
  localparam int L = 12;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] data = '0;
  logic [N-1:0] level;
  logic         sample_tick;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [1:0]   evt_ch;
  logic         evt_rise;
  logic         evt_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_ctrl #(
    .CH_NUM    (N),
    .PRESCALE  (P),
    .STABLE_CNT(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .level      (level),
    .sample_tick(sample_tick),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_rise   (evt_rise),
    .evt_ovf    (evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  bit         m_live = 0;
  int         m_pc;
  int         m_run [N];
  bit [N-1:0] m_lvl, m_pend, m_edg, m_s, m_ev, m_d1, m_d2;
  bit [N-1:0] pend_pre, edg_pre, req;
  bit         m_ovf, m_valid, m_rise, m_tick, m_hs;
  int         m_ch, m_rr, ch_pre, g;

  function automatic int pick(input bit [N-1:0] r, input int start);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live  = 1;
      m_pc    = 0;
      m_tick  = 0;
      m_lvl   = '0;
      m_pend  = '0;
      m_edg   = '0;
      m_ovf   = 0;
      m_valid = 0;
      m_ch    = 0;
      m_rise  = 0;
      m_rr    = N - 1;
      m_d1    = '0;
      m_d2    = '0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
    end else begin
`ifdef DEBOUNCE_SYNC2_EN
      m_s  = m_d2;
      m_d2 = m_d1;
      m_d1 = data;
`else
      m_s = data;
`endif
      m_ev = '0;
      if (m_pc == P - 1) begin
        for (int c = 0; c < N; c++) begin
          if (m_s[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == S) begin
              m_run[c] = 0;
              m_lvl[c] = ~m_lvl[c];
              m_ev[c]  = 1;
            end
          end else begin
            m_run[c] = 0;
          end
        end
      end
      m_hs     = m_valid && evt_ready;
      pend_pre = m_pend;
      edg_pre  = m_edg;
      ch_pre   = m_ch;
      if (!m_valid) begin
        g = pick(pend_pre, (m_rr + 1) % N);
        if (g >= 0) begin
          m_valid = 1;
          m_ch    = g;
          m_rise  = edg_pre[g];
        end
      end else if (m_hs) begin
        m_rr = ch_pre;
        m_pend[ch_pre] = 0;
        req = pend_pre;
        req[ch_pre] = 0;
        g = pick(req, (ch_pre + 1) % N);
        if (g >= 0) begin
          m_ch   = g;
          m_rise = edg_pre[g];
        end else begin
          m_valid = 0;
        end
      end
      for (int c = 0; c < N; c++) begin
        if (m_ev[c]) begin
          if (pend_pre[c] && !(m_hs && c == ch_pre)) m_ovf = 1;
          m_pend[c] = 1;
          m_edg[c]  = m_lvl[c];
        end
      end
      m_pc   = (m_pc + 1) % P;
      m_tick = (m_pc == P - 1);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("level",       int'(level),       int'(m_lvl));
      check("sample_tick", int'(sample_tick), int'(m_tick));
      check("evt_valid",   int'(evt_valid),   int'(m_valid));
      check("evt_ch",      int'(evt_ch),      m_ch);
      check("evt_rise",    int'(evt_rise),    int'(m_rise));
      check("evt_ovf",     int'(evt_ovf),     int'(m_ovf));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_zero_outputs(input string tag);
    check({tag, "_level"}, int'(level),       0);
    check({tag, "_tick"},  int'(sample_tick), 0);
    check({tag, "_valid"}, int'(evt_valid),   0);
    check({tag, "_ch"},    int'(evt_ch),      0);
    check({tag, "_rise"},  int'(evt_rise),    0);
    check({tag, "_ovf"},   int'(evt_ovf),     0);
  endtask

  initial begin
    // Steady press on ch0 applied one cycle before the first tick
    data = '0;
    evt_ready = 1'b1;
    do_reset();
    expect_zero_outputs("rst");
    repeat (3) @(negedge clk);
    check("first_tick", int'(sample_tick), 1);
    data = 4'b0001;
    repeat (L - 4) @(negedge clk);
    check("press_level_before", int'(level[0]), 0);
    @(negedge clk);
    check("press_level_after", int'(level[0]), 1);
    @(negedge clk);
    check("press_valid", int'(evt_valid), 1);
    check("press_ch",    int'(evt_ch),    0);
    check("press_rise",  int'(evt_rise),  1);
    @(negedge clk);
    check("press_done",  int'(evt_valid), 0);

    // Glitch lasting two ticks
    data = '0;
    do_reset();
    repeat (3) @(negedge clk);
    data = 4'b0010;
    repeat (8) @(negedge clk);
    data = '0;
    repeat (30) @(negedge clk);
    check("glitch_level", int'(level),     0);
    check("glitch_valid", int'(evt_valid), 0);

    // All four channels rise on one tick
    do_reset();
    repeat (3) @(negedge clk);
    data = 4'b1111;
    repeat (L - 3) @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("rr_valid", int'(evt_valid), 1);
      check("rr_order", int'(evt_ch),    k);
      @(negedge clk);
    end
    check("rr_drained", int'(evt_valid), 0);

    // ch2 rises then falls with the consumer stalled
    data = '0;
    evt_ready = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    data = 4'b0100;
    repeat (L - 3) @(negedge clk);
    data = '0;
    repeat (13) @(negedge clk);
    check("ovf_valid", int'(evt_valid), 1);
    check("ovf_ch",    int'(evt_ch),    2);
    check("ovf_rise",  int'(evt_rise),  1);
    check("ovf_flag",  int'(evt_ovf),   1);
    check("ovf_level", int'(level[2]),  0);
    evt_ready = 1'b1;
    @(negedge clk);
    check("ovf_hs_valid",  int'(evt_valid), 0);
    check("ovf_sticky",    int'(evt_ovf),   1);

    // Reset in the middle of an offer, with the pointer moved off its reset value
    data = '0;
    do_reset();
    repeat (3) @(negedge clk);
    data = 4'b0001;
    repeat (L - 3) @(negedge clk);
    repeat (2) @(negedge clk);
    evt_ready = 1'b0;
    data = 4'b0011;
    repeat (20) @(negedge clk);
    check("mid_valid", int'(evt_valid), 1);
    check("mid_ch",    int'(evt_ch),    1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_zero_outputs("midrst");
    repeat (13) @(negedge clk);
    check("post_rst_valid", int'(evt_valid), 1);
    check("post_rst_ch",    int'(evt_ch),    0);
    evt_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ch2",   int'(evt_ch),    1);

    // Randomized traffic
    data = '0;
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int rdy_pct;
      int flip_div;
      rdy_pct  = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 95);
      flip_div = (seg % 2 == 0) ? 40 : 8;
      for (int cyc = 0; cyc < 500; cyc++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 999) == 0);
        evt_ready = ($urandom_range(0, 99) < rdy_pct);
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(0, flip_div - 1) == 0) data[c] = ~data[c];
        end
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_ctrl.md
DEBOUNCE_CTRL -- requirements
Module: debounce_ctrl

Interface
REQ-001 Parameter CH_NUM, default 4, SHALL set the number of debounced input channels (2..8).
REQ-002 Parameter PRESCALE, default 1000, SHALL set the clk cycles per sample tick (>=2).
REQ-003 Parameter STABLE_CNT, default 11, SHALL set the consecutive differing samples needed to change a level (1..15).
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 data  input  CH_NUM  SHALL carry the raw, bouncing contact inputs, one bit per channel.
REQ-007 level  output  CH_NUM  SHALL carry the debounced level per channel.
REQ-008 sample_tick  output  1  SHALL pulse for one cycle on each sampling instant.
REQ-009 evt_valid  output  1  SHALL indicate that an edge event is offered.
REQ-010 evt_ready  input  1  SHALL indicate that the consumer accepts the offered event.
REQ-011 evt_ch  output  clog2(CH_NUM)  SHALL carry the channel index of the offered event.
REQ-012 evt_rise  output  1  SHALL be 1 for a rising (press) event and 0 for a falling (release) event.
REQ-013 evt_ovf  output  1  SHALL be a sticky flag indicating that an undelivered event was overwritten.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1, wrap to 0, and assert sample_tick in the cycle where the count equals PRESCALE-1.
REQ-015 On each tick, each channel SHALL compare its sample s with level: if s != level, its counter increments; otherwise the counter clears to 0.
REQ-016 When a tick makes a channel counter reach STABLE_CNT, that channel SHALL toggle level, clear its counter, and set its pending flag with edge = new level, all on the same clock edge.
REQ-017 Between ticks, channel counters and level SHALL hold.
REQ-018 Counters SHALL be ceil(log2(STABLE_CNT+1)) bits wide and never wrap.
REQ-019 Arbiter SHALL be round-robin: search starts at channel (last granted + 1) mod CH_NUM, and the first pending channel wins.
REQ-020 Output FSM SHALL have two states, IDLE and OFFER; IDLE->OFFER when any flag is pending, with evt_valid/evt_ch/evt_rise registered (1-cycle latency after the flag sets).
REQ-021 In OFFER, evt_ch and evt_rise SHALL remain stable until evt_valid && evt_ready.
REQ-022 On handshake, the FSM SHALL clear the granted pending flag and update the round-robin pointer; it goes to OFFER if another flag is pending in the same cycle, else to IDLE.
REQ-023 If a new event hits a channel whose flag is pending and not being handshaken, the flag SHALL stay set, the edge SHALL be overwritten, and evt_ovf SHALL set; if that channel is currently offered, evt_rise SHALL still be unchanged until handshake.
REQ-024 If a new event and a handshake hit the same channel in the same cycle, the flag SHALL remain set with the new edge and evt_ovf SHALL NOT set.
REQ-025 A data glitch shorter than STABLE_CNT ticks SHALL produce no level change and no event.

Reset
REQ-026 When reset=1 at a clock edge, the following SHALL clear to 0 on that edge: prescaler, counters, level, pending flags, sample_tick, evt_valid, evt_ch, evt_rise, evt_ovf; the round-robin pointer SHALL be set to CH_NUM-1.
REQ-027 Reset SHALL take priority over every other event, including one asserted mid-offer, which drops the offered event without a handshake.

Configuration
REQ-028 With macro DEBOUNCE_SYNC2_EN defined, data SHALL pass through a 2-flop synchronizer (reset to 0) before sampling, adding 2 cycles of input latency.
REQ-029 Without DEBOUNCE_SYNC2_EN, data SHALL be sampled directly on the tick.

Verification
(All scenarios use PRESCALE=4, STABLE_CNT=3, CH_NUM=4, with the macro undefined unless stated.)
REQ-030 Set data[0]=1 steadily -> level[0] rises on the 3rd tick edge, one event ch=0 rise=1 follows, then evt_valid low after the handshake.
REQ-031 Set data[1]=1 for 2 ticks then 0 -> no level change, evt_valid stays 0.
REQ-032 Toggle data[3:0] 0->1 on the same tick with evt_ready=1 -> events delivered in order ch0, ch1, ch2, ch3, one per handshake.
REQ-033 Hold evt_ready=0 while ch2 rises then falls -> one pending event ch2 rise=0 remains, evt_ovf=1.
REQ-034 Assert reset during OFFER -> next cycle all outputs are 0, and a later event on ch0 is granted first.
REQ-035 With DEBOUNCE_SYNC2_EN defined, repeat REQ-030 aligned 1 cycle before a tick -> the level change moves by one tick versus the unsynchronized build.
